// File: rtl/pc_gen_pkg.sv
// Shared defines for the fetch front end: chip-enable polarity, branch and
// stall encodings, and the default widths and boot address used by pc_gen.
// Ports: none (package only).
package pc_gen_pkg;

  // Default geometry of the fetch path.
  localparam int          DEF_ADDR_W       = 32;
  localparam int          DEF_STALL_W      = 6;
  localparam int          DEF_STEP         = 4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h3000_0000;

  // Instruction memory chip-enable levels.
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  // Decode branch request level.
  localparam logic BRANCH = 1'b1;

  // Stall bit level meaning "stage is free to advance".
  localparam logic NO_STOP = 1'b0;

endpackage : pc_gen_pkg

// File: rtl/pc_gen.sv
// Program counter generator: produces the registered fetch address and
// instruction-memory chip enable, handling flush, stall, branch and a single
// branch captured while stalled.
// Ports:
//   clk                     sole clock, all state changes on its rising edge
//   rst                     asynchronous active-low reset
//   stall                   pipeline stall vector, bit 0 is the fetch stage
//   branch_flag_i           decode requests a taken branch
//   branch_target_address_i branch target
//   flush                   exception flush from the controller
//   new_pc                  exception handler entry address
//   pc                      current fetch address (registered)
//   ce                      instruction memory chip enable (registered)
//   branch_pending_o        a branch captured during a stall is being held
//   misalign_o              one-cycle pulse: last loaded target was not STEP-aligned
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W       = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
  // Sequential increment in bytes; must be a power of two in 1..16.
  parameter int                STEP         = DEF_STEP,
  parameter int                STALL_W      = DEF_STALL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_address_i,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               branch_pending_o,
  output logic               misalign_o
);

  // BOOT holds the reset vector with memory disabled for one edge so the very
  // first fetch (issued in RUN) is at RESET_VECTOR rather than one step past it.
  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc_n;
  logic              ce_n;
  logic              pend_n;
  logic              mis_n;
  logic [ADDR_W-1:0] pend_tgt, pend_tgt_n;
  logic [ADDR_W:0]   redirect;

  // Only the fetch stage bit drives this block; the rest of the vector is
  // consumed here purely to keep the whole port connected.
  logic unused_stall;
  assign unused_stall = ^stall;

  // Clears the low log2(STEP) address bits and reports whether any were set.
  // Result packs {misaligned, aligned_address}.
  function automatic logic [ADDR_W:0] align_target(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] mask;
    mask = ADDR_W'(STEP - 1);
    return {|(addr & mask), addr & ~mask};
  endfunction

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= BOOT;
      pc               <= RESET_VECTOR;
      ce               <= CHIP_DISABLE;
      branch_pending_o <= 1'b0;
      pend_tgt         <= '0;
      misalign_o       <= 1'b0;
    end else begin
      state            <= state_n;
      pc               <= pc_n;
      ce               <= ce_n;
      branch_pending_o <= pend_n;
      pend_tgt         <= pend_tgt_n;
      misalign_o       <= mis_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    ce_n       = CHIP_DISABLE;
    pend_n     = branch_pending_o;
    pend_tgt_n = pend_tgt;
    mis_n      = 1'b0;
    redirect   = '0;

    case (state)
      BOOT: begin
        // Leave BOOT on the first edge out of reset without advancing pc.
        state_n    = RUN;
        pc_n       = RESET_VECTOR;
        ce_n       = CHIP_ENABLE;
        pend_n     = 1'b0;
        pend_tgt_n = '0;
      end

      RUN: begin
        ce_n = CHIP_ENABLE;
        if (flush) begin
          // Exception redirect wins over everything, including a stall, and
          // drops any branch that was waiting for the stall to clear.
          redirect   = align_target(new_pc);
          pc_n       = redirect[ADDR_W-1:0];
          mis_n      = redirect[ADDR_W];
          pend_n     = 1'b0;
          pend_tgt_n = '0;
        end else if (stall[0] != NO_STOP) begin
          // Hold pc. A branch resolved during the stall would otherwise be
          // lost, so remember the first one; later requests are ignored.
          if (branch_flag_i == BRANCH && !branch_pending_o) begin
            pend_n     = 1'b1;
            pend_tgt_n = branch_target_address_i;
          end
        end else if (branch_pending_o) begin
          // The held branch is older than anything decode presents now.
          redirect   = align_target(pend_tgt);
          pc_n       = redirect[ADDR_W-1:0];
          mis_n      = redirect[ADDR_W];
          pend_n     = 1'b0;
          pend_tgt_n = '0;
        end else if (branch_flag_i == BRANCH) begin
          redirect = align_target(branch_target_address_i);
          pc_n     = redirect[ADDR_W-1:0];
          mis_n    = redirect[ADDR_W];
        end else begin
          // Natural wrap at 2^ADDR_W.
          pc_n = pc + ADDR_W'(STEP);
        end
      end

      default: begin
        state_n = BOOT;
      end
    endcase
  end

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen with default parameters.
module tb_pc_gen;

  localparam int          ADDR_W  = 32;
  localparam int          STALL_W = 6;
  localparam logic [31:0] RV      = 32'h3000_0000;

  logic              clk;
  logic              rst;
  logic [STALL_W-1:0] stall;
  logic              branch_flag_i;
  logic [ADDR_W-1:0] branch_target_address_i;
  logic              flush;
  logic [ADDR_W-1:0] new_pc;
  logic [ADDR_W-1:0] pc;
  logic              ce;
  logic              branch_pending_o;
  logic              misalign_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  pc_gen #(
    .ADDR_W      (ADDR_W),
    .RESET_VECTOR(RV),
    .STEP        (4),
    .STALL_W     (STALL_W)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .stall                  (stall),
    .branch_flag_i          (branch_flag_i),
    .branch_target_address_i(branch_target_address_i),
    .flush                  (flush),
    .new_pc                 (new_pc),
    .pc                     (pc),
    .ce                     (ce),
    .branch_pending_o       (branch_pending_o),
    .misalign_o             (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are observed and inputs changed 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = '0; branch_flag_i = 1'b0; branch_target_address_i = '0;
    flush = 1'b0; new_pc = '0;
    tick(); tick();
    chk_cnt++; if (pc !== RV) $display("FAIL reset_pc got=%h exp=%h", pc, RV); else pass_cnt++;
    chk_cnt++; if (ce !== 1'b0) $display("FAIL reset_ce got=%b exp=0", ce); else pass_cnt++;
    chk_cnt++; if (branch_pending_o !== 1'b0) $display("FAIL reset_pend got=%b exp=0", branch_pending_o); else pass_cnt++;
    chk_cnt++; if (misalign_o !== 1'b0) $display("FAIL reset_mis got=%b exp=0", misalign_o); else pass_cnt++;
  endtask

  task automatic test_boot();
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'h3000_0000; exp_seq[1] = 32'h3000_0004; exp_seq[2] = 32'h3000_0008;
    rst = 1'b1;
    #1;
    chk_cnt++; if (ce !== 1'b0) $display("FAIL boot_ce_pre got=%b exp=0", ce); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cnt++; if (ce !== 1'b1) $display("FAIL boot_ce[%0d] got=%b exp=1", i, ce); else pass_cnt++;
      chk_cnt++; if (pc !== exp_seq[i]) $display("FAIL boot_pc[%0d] got=%h exp=%h", i, pc, exp_seq[i]); else pass_cnt++;
      chk_cnt++; if (misalign_o !== 1'b0) $display("FAIL boot_mis[%0d] got=%b exp=0", i, misalign_o); else pass_cnt++;
    end
  endtask

  task automatic test_stall_branch();
    // pc is 30000008 here.
    stall = 6'b000001; branch_flag_i = 1'b1; branch_target_address_i = 32'h3000_0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      // A later branch request during the stall must not replace the first.
      branch_target_address_i = 32'h3000_0200;
      chk_cnt++; if (pc !== 32'h3000_0008) $display("FAIL stall_hold_pc[%0d] got=%h exp=30000008", i, pc); else pass_cnt++;
      chk_cnt++; if (branch_pending_o !== 1'b1) $display("FAIL stall_pend[%0d] got=%b exp=1", i, branch_pending_o); else pass_cnt++;
    end
    // Release with a fresh branch request present: the held target wins.
    stall = '0; branch_flag_i = 1'b1; branch_target_address_i = 32'h3000_0300;
    tick();
    chk_cnt++; if (pc !== 32'h3000_0100) $display("FAIL release_pc got=%h exp=30000100", pc); else pass_cnt++;
    chk_cnt++; if (branch_pending_o !== 1'b0) $display("FAIL release_pend got=%b exp=0", branch_pending_o); else pass_cnt++;
    chk_cnt++; if (misalign_o !== 1'b0) $display("FAIL release_mis got=%b exp=0", misalign_o); else pass_cnt++;
    branch_flag_i = 1'b0;
    tick();
    chk_cnt++; if (pc !== 32'h3000_0104) $display("FAIL post_release_pc got=%h exp=30000104", pc); else pass_cnt++;
    // Upper stall bits do not stall fetch.
    stall = 6'b111110;
    tick();
    chk_cnt++; if (pc !== 32'h3000_0108) $display("FAIL upper_stall_pc got=%h exp=30000108", pc); else pass_cnt++;
    stall = '0;
  endtask

  task automatic test_flush_over_pending();
    // pc is 30000108 here.
    stall = 6'b000001; branch_flag_i = 1'b1; branch_target_address_i = 32'h3000_0200;
    tick();
    chk_cnt++; if (branch_pending_o !== 1'b1) $display("FAIL flush_setup_pend got=%b exp=1", branch_pending_o); else pass_cnt++;
    branch_flag_i = 1'b0; flush = 1'b1; new_pc = 32'h0000_0380;
    tick();
    chk_cnt++; if (pc !== 32'h0000_0380) $display("FAIL flush_pc got=%h exp=00000380", pc); else pass_cnt++;
    chk_cnt++; if (branch_pending_o !== 1'b0) $display("FAIL flush_pend got=%b exp=0", branch_pending_o); else pass_cnt++;
    flush = 1'b0; stall = '0;
    tick();
    chk_cnt++; if (pc !== 32'h0000_0384) $display("FAIL after_flush_pc got=%h exp=00000384", pc); else pass_cnt++;
  endtask

  task automatic test_misalign();
    branch_flag_i = 1'b1; branch_target_address_i = 32'h3000_0102;
    tick();
    chk_cnt++; if (pc !== 32'h3000_0100) $display("FAIL mis_br_pc got=%h exp=30000100", pc); else pass_cnt++;
    chk_cnt++; if (misalign_o !== 1'b1) $display("FAIL mis_br_pulse got=%b exp=1", misalign_o); else pass_cnt++;
    branch_flag_i = 1'b0;
    tick();
    chk_cnt++; if (pc !== 32'h3000_0104) $display("FAIL mis_br_next_pc got=%h exp=30000104", pc); else pass_cnt++;
    chk_cnt++; if (misalign_o !== 1'b0) $display("FAIL mis_br_clear got=%b exp=0", misalign_o); else pass_cnt++;
    flush = 1'b1; new_pc = 32'h0000_0383;
    tick();
    chk_cnt++; if (pc !== 32'h0000_0380) $display("FAIL mis_fl_pc got=%h exp=00000380", pc); else pass_cnt++;
    chk_cnt++; if (misalign_o !== 1'b1) $display("FAIL mis_fl_pulse got=%b exp=1", misalign_o); else pass_cnt++;
    flush = 1'b0; stall = 6'b000001;
    tick();
    chk_cnt++; if (misalign_o !== 1'b0) $display("FAIL mis_hold_clear got=%b exp=0", misalign_o); else pass_cnt++;
    // Misaligned target captured while stalled is aligned when it is loaded.
    branch_flag_i = 1'b1; branch_target_address_i = 32'h3000_0401;
    tick();
    chk_cnt++; if (misalign_o !== 1'b0) $display("FAIL mis_capture_quiet got=%b exp=0", misalign_o); else pass_cnt++;
    branch_flag_i = 1'b0; stall = '0;
    tick();
    chk_cnt++; if (pc !== 32'h3000_0400) $display("FAIL mis_pend_pc got=%h exp=30000400", pc); else pass_cnt++;
    chk_cnt++; if (misalign_o !== 1'b1) $display("FAIL mis_pend_pulse got=%b exp=1", misalign_o); else pass_cnt++;
  endtask

  task automatic test_wrap();
    branch_flag_i = 1'b1; branch_target_address_i = 32'hFFFF_FFFC;
    tick();
    chk_cnt++; if (pc !== 32'hFFFF_FFFC) $display("FAIL wrap_setup_pc got=%h exp=fffffffc", pc); else pass_cnt++;
    branch_flag_i = 1'b0;
    tick();
    chk_cnt++; if (pc !== 32'h0000_0000) $display("FAIL wrap_pc got=%h exp=00000000", pc); else pass_cnt++;
    tick();
    chk_cnt++; if (pc !== 32'h0000_0004) $display("FAIL wrap_next_pc got=%h exp=00000004", pc); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    stall = 6'b000001; branch_flag_i = 1'b1; branch_target_address_i = 32'h3000_0500;
    tick();
    chk_cnt++; if (branch_pending_o !== 1'b1) $display("FAIL ar_setup_pend got=%b exp=1", branch_pending_o); else pass_cnt++;
    // Assert reset between edges; outputs must react without a clock edge.
    #2 rst = 1'b0;
    #1;
    chk_cnt++; if (pc !== RV) $display("FAIL ar_pc got=%h exp=%h", pc, RV); else pass_cnt++;
    chk_cnt++; if (ce !== 1'b0) $display("FAIL ar_ce got=%b exp=0", ce); else pass_cnt++;
    chk_cnt++; if (branch_pending_o !== 1'b0) $display("FAIL ar_pend got=%b exp=0", branch_pending_o); else pass_cnt++;
    stall = '0; branch_flag_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk_cnt++; if (pc !== RV || ce !== 1'b1) $display("FAIL ar_reboot got pc=%h ce=%b exp pc=%h ce=1", pc, ce, RV); else pass_cnt++;
    tick();
    // The discarded branch must not reappear after the reboot.
    chk_cnt++; if (pc !== 32'h3000_0004) $display("FAIL ar_seq_pc got=%h exp=30000004", pc); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    // Consecutive branches on consecutive edges, then sequential.
    branch_flag_i = 1'b1; branch_target_address_i = 32'h0000_1000;
    tick();
    chk_cnt++; if (pc !== 32'h0000_1000) $display("FAIL b2b_pc0 got=%h exp=00001000", pc); else pass_cnt++;
    branch_target_address_i = 32'h0000_2000;
    tick();
    chk_cnt++; if (pc !== 32'h0000_2000) $display("FAIL b2b_pc1 got=%h exp=00002000", pc); else pass_cnt++;
    branch_flag_i = 1'b0;
    tick();
    chk_cnt++; if (pc !== 32'h0000_2004) $display("FAIL b2b_pc2 got=%h exp=00002004", pc); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_boot();
    test_stall_branch();
    test_flush_over_pending();
    test_misalign();
    test_wrap();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_pc_gen

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning PC width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h30000000, meaning first fetch address after reset.
REQ-003 SHALL have parameter STEP, default 4, meaning sequential increment in bytes; power of two, 1..16.
REQ-004 SHALL have parameter STALL_W, default 6, meaning stall vector width; bit 0 is the fetch stage.
REQ-005 SHALL have clk  input  1  meaning sole clock; all state changes on its rising edge.
REQ-006 SHALL have rst  input  1  meaning reset, asynchronous, active-low.
REQ-007 SHALL have stall  input  STALL_W  meaning pipeline stall vector; only bit 0 is used.
REQ-008 SHALL have branch_flag_i  input  1  meaning decode requests a taken branch.
REQ-009 SHALL have branch_target_address_i  input  ADDR_W  meaning branch target.
REQ-010 SHALL have flush  input  1  meaning exception flush from the controller.
REQ-011 SHALL have new_pc  input  ADDR_W  meaning exception handler entry address.
REQ-012 SHALL have pc  output  ADDR_W  meaning current fetch address, registered.
REQ-013 SHALL have ce  output  1  meaning instruction memory chip enable, registered.
REQ-014 SHALL have branch_pending_o  output  1  meaning a branch captured during a stall is held.
REQ-015 SHALL have misalign_o  output  1  meaning the last redirect target was not STEP-aligned; one-cycle pulse.

Function
REQ-016 SHALL implement a two-state FSM: BOOT (ce=0, pc=RESET_VECTOR) and RUN (ce=1).
REQ-017 SHALL move BOOT->RUN on the first rising edge with rst high; pc stays RESET_VECTOR on that edge, so the first fetch is at RESET_VECTOR.
REQ-018 SHALL, in RUN, update pc on each edge with priority: flush > stall[0] > pending branch > branch_flag_i > sequential.
REQ-019 SHALL load new_pc on flush regardless of stall, and clear any pending branch on the same edge.
REQ-020 SHALL hold pc when stall[0]=1 and flush=0.
REQ-021 SHALL, when stall[0]=1, branch_flag_i=1 and no branch is pending, capture branch_target_address_i and set branch_pending_o on that edge.
REQ-022 SHALL ignore branch_flag_i while a branch is pending; the first captured target is kept.
REQ-023 SHALL, on the first edge with stall[0]=0 and a branch pending, load the pending target, ignore branch_flag_i, and clear branch_pending_o.
REQ-024 SHALL load branch_target_address_i when stall[0]=0, no branch is pending and branch_flag_i=1.
REQ-025 SHALL otherwise advance pc to pc+STEP modulo 2^ADDR_W; all-ones minus STEP+1 wraps to 0.
REQ-026 SHALL force the low log2(STEP) bits of every loaded target (new_pc, branch, pending) to zero, and pulse misalign_o high for one cycle, coincident with the pc update, if any of those bits were set.
REQ-027 SHALL hold misalign_o low in BOOT and on sequential or hold edges.

Reset
REQ-028 SHALL, while rst=0, immediately set pc=RESET_VECTOR, ce=0, branch_pending_o=0, misalign_o=0, pending target=0, FSM=BOOT.
REQ-029 SHALL discard any pending branch or in-flight redirect on reset mid-operation and restart via BOOT.

Structure
REQ-030 SHALL source ChipEnable/ChipDisable, Branch, NoStop and default widths from the shared defines package; FSM state encodings remain local.
REQ-031 SHALL be a single module with no sub-modules; target alignment and misalign detection are a local function.

Verification
REQ-032 SHALL cover boot: release rst -> ce=0 with pc=32'h30000000 for one edge, then ce=1 and pc sequence 30000000, 30000004, 30000008.
REQ-033 SHALL cover stall plus branch: stall[0]=1 for 3 cycles with branch_flag_i=1 and target 30000100 -> pc held, branch_pending_o=1; on release pc=30000100 and pending clears.
REQ-034 SHALL cover flush over pending: branch pending, flush=1 with new_pc=00000380 while stalled -> pc=00000380 and branch_pending_o=0 on the same edge.
REQ-035 SHALL cover misalignment: STEP=4, branch target 30000102 -> pc=30000100 and misalign_o high for exactly one cycle.
REQ-036 SHALL cover wrap: pc=FFFFFFFC, no events -> next pc=00000000.
REQ-037 SHALL cover async reset: rst low mid-stall with a branch pending -> pc=RESET_VECTOR, ce=0 and pending=0 before the next edge.
